progmem_dump: RTL and testbench
===============================

# progmem_dump

Program-memory readback engine. On a start request it reads every byte of the 4 KiB program RAM in ascending address order and streams the bytes out over a valid/ready byte interface, e.g. to a UART transmitter or a debug port. It sits beside the program RAM, and the external loader owns the write side of that RAM. `progmem_dump` takes over the RAM read port only while the dump runs.

## Interface
Parameters:
- `ADDR_W`, 12: RAM byte-address width.
- `NBYTES`, 4096: number of bytes dumped, starting at address 0. Range 1..2^ADDR_W.

Ports:
- `clk`, in, 1: clock.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a dump.
- `loaded`, in, 1: program RAM load is complete and the RAM is readable.
- `mem_ce`, out, 1: RAM chip enable, active-high. Asserted for one cycle per read.
- `mem_addr`, out, ADDR_W: RAM byte address.
- `mem_dout`, in, 8: RAM read data. Valid the cycle after `mem_ce` is sampled.
- `tx_data`, out, 8: streamed byte.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: the sink accepts the byte.
- `busy`, out, 1: a dump is in progress.
- `done`, out, 1: one-cycle pulse after the final byte is accepted.

## Operation
- State machine states: IDLE, REQ, WAIT, SEND, CSUM, FIN.
- **IDLE**
  - `start`=1 and `loaded`=1 → clear `ptr` and `sum`, go to REQ.
  - `start` while `loaded`=0 is ignored.
  - `start` in any other state is ignored.
- **REQ:** drive `mem_ce`=1 and `mem_addr`=`ptr`, then go to WAIT.
- **WAIT:** `mem_dout` is valid. Latch it into `tx_data`, add it to `sum` (8-bit, mod 256), then go to SEND.
- **SEND:** `tx_valid`=1, with `tx_data` held stable.
  - On `tx_valid`&&`tx_ready`: if `ptr`==NBYTES-1, go to CSUM (macro on) or FIN (macro off). Otherwise increment `ptr` and go to REQ.
- **CSUM** (macro on only): `tx_data` = (~`sum`)+1 and `tx_valid`=1. On handshake, go to FIN.
- **FIN:** `done`=1 for one cycle, then go to IDLE.
- `busy` is 1 in every state except IDLE.
- `mem_ce` is 0 and `mem_addr` holds its last value outside REQ.
- `ptr` is ADDR_W+1 bits wide so that NBYTES=2^ADDR_W does not wrap before the compare.
- `mem_addr` = `ptr`[ADDR_W-1:0].
- `loaded` dropping mid-dump aborts the dump to IDLE on the next edge: `tx_valid` drops and no `done` is issued.

## Timing
- Reset values:
  - `mem_ce`=0, `mem_addr`=0.
  - `tx_data`=0x00, `tx_valid`=0.
  - `busy`=0, `done`=0.
  - State = IDLE, `ptr`=0, `sum`=0.
- Asserting `n_reset` mid-dump aborts immediately (asynchronous). `done` is not issued.
- Start latency: `start` sampled at edge 0 → `mem_ce`=1 in cycle 1 → first `tx_valid` in cycle 3.
- Per byte with `tx_ready` tied high: 3 cycles (REQ, WAIT, SEND).
  - Full dump: 3·NBYTES cycles, plus 1 for the checksum byte if enabled, plus 1 for FIN.
- `tx_valid` never drops without a handshake, except on abort or reset.
- `tx_valid` does not depend combinationally on `tx_ready`.
- `done` is asserted in the cycle after the final handshake. `busy` goes low in the cycle after `done`.
- A `start` in the same cycle as `done` is ignored.

## Configuration
- Macro `DUMP_CHECKSUM_EN`.
- Defined: after the last data byte, one extra byte is sent, equal to the two's complement of the mod-256 sum of all data bytes. The sum of all NBYTES+1 streamed bytes is 0x00 mod 256.
- Undefined: the CSUM state and the `sum` register are absent, and exactly NBYTES bytes are streamed.

## Test plan
- NBYTES=4, RAM = {0x11,0x22,0x33,0x44}, `tx_ready`=1, macro on → stream 11,22,33,44,56; `done` pulses exactly once; total 3·4+1+1 = 14 cycles from REQ to FIN.
- Same setup, macro off → exactly 4 bytes; `done` asserted the cycle after 0x44 is accepted.
- `tx_ready` low for 5 cycles on byte 2 → `tx_data`=0x22 and `tx_valid`=1 held stable throughout; no `mem_ce` pulse until the byte is accepted.
- `start` with `loaded`=0 → `busy` stays 0 and `mem_ce` stays 0. `start` while busy → no restart; `ptr` sequence unaffected.
- NBYTES=4096, RAM[a] = a[7:0] → 4096 bytes 00..FF repeating, `mem_addr` reaching 0xFFF, checksum 0x00.
- `n_reset` pulsed after byte 1, or `loaded` dropped after byte 2 → all outputs return to reset values, no `done`; a following `start` restarts from address 0.

Source files
------------

// File: rtl/progmem_dump.sv
// progmem_dump: reads program RAM from address 0 upward and streams each byte over a valid/ready port.
// Build option DUMP_CHECKSUM_EN appends a byte that makes the mod-256 sum of the stream zero.
module progmem_dump #(
    parameter int ADDR_W = 12,
    parameter int NBYTES = 4096
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              loaded,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, CSUM, FIN} state_t;
    // ptr has one spare bit so a full 2^ADDR_W dump still reaches the last-byte compare
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NBYTES - 1);
    state_t          state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic [7:0]      data_q, data_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]      sum_q, sum_d;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
`ifdef DUMP_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: if (start && loaded) begin
                state_d = REQ;
                ptr_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                data_d  = mem_dout;
`ifdef DUMP_CHECKSUM_EN
                sum_d   = sum_q + mem_dout;
`endif
                state_d = SEND;
            end
            SEND: if (tx_ready) begin
                if (ptr_q == LAST) begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = CSUM;
                    data_d  = ~sum_q + 8'd1;
`else
                    state_d = FIN;
`endif
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = REQ;
                end
            end
            CSUM: if (tx_ready) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Losing the RAM mid-dump abandons it and restores the idle outputs
        if (state_q != IDLE && !loaded) begin
            state_d = IDLE;
            ptr_d   = '0;
            data_d  = '0;
`ifdef DUMP_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
    assign mem_ce   = state_q == REQ;
    assign mem_addr = ptr_q[ADDR_W-1:0];
    assign tx_data  = data_q;
    assign tx_valid = state_q == SEND || state_q == CSUM;
    assign busy     = state_q != IDLE;
    assign done     = state_q == FIN;
endmodule

// File: tb/tb_progmem_dump.sv
// tb_progmem_dump: table-driven and randomized checks of progmem_dump on a 4-byte and a 4096-byte RAM.
module tb_progmem_dump;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 0, n_reset = 0;
    always #5 clk = ~clk;
    logic start = 0, loaded = 0, tx_ready = 0;
    logic mem_ce, tx_valid, busy, done;
    logic [11:0] mem_addr;
    logic [7:0] mem_dout, tx_data;
    logic [7:0] ram [4];
    progmem_dump #(.ADDR_W(12), .NBYTES(4)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .loaded(loaded),
        .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );
    always_ff @(posedge clk) if (mem_ce) mem_dout <= ram[mem_addr[1:0]];
    logic start_b = 0, ce_b, valid_b, busy_b, done_b;
    logic [11:0] addr_b;
    logic [7:0] dout_b, data_b;
    progmem_dump #(.ADDR_W(12), .NBYTES(4096)) dut_b (
        .clk(clk), .n_reset(n_reset), .start(start_b), .loaded(1'b1),
        .mem_ce(ce_b), .mem_addr(addr_b), .mem_dout(dout_b),
        .tx_data(data_b), .tx_valid(valid_b), .tx_ready(1'b1),
        .busy(busy_b), .done(done_b)
    );
    always_ff @(posedge clk) if (ce_b) dout_b <= addr_b[7:0];

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    logic [11:0] addr_q[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (mem_ce) addr_q.push_back(mem_addr);
        if (done) done_cnt++;
    end

    int nb = 0, badb = 0, cyc_b = 0;
    logic [11:0] maxa = 0;
    logic [7:0] csum_b;
    always @(negedge clk) begin
        if (busy_b) cyc_b++;
        if (ce_b && addr_b > maxa) maxa = addr_b;
        if (valid_b) begin
            if (data_b !== (nb < 4096 ? 8'(nb) : csum_b)) badb++;
            nb++;
        end
    end

    logic [7:0] got_q[$];
    int busy_cyc, stall_seen, unstable;
    task automatic run_dump(input int stall_idx, input int stall_len, input int poke, input bit rnd);
        int k = 0, st = 0;
        logic [7:0] hold = 0;
        bit prev_stall = 0;
        got_q.delete(); addr_q.delete();
        done_cnt = 0; busy_cyc = 0; stall_seen = 0; unstable = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        while (!done && k < 400) begin
            busy_cyc += int'(busy);
            if (prev_stall && (!tx_valid || tx_data !== hold)) unstable++;
            if (tx_valid && mem_ce) unstable++;
            start = (poke == 1 && k == 4);
            if (tx_valid) begin
                tx_ready = rnd ? ($urandom_range(0, 2) != 0) : !(got_q.size() == stall_idx && st < stall_len);
                if (!tx_ready) begin st++; stall_seen++; end
                else got_q.push_back(tx_data);
            end else tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_stall = tx_valid && !tx_ready;
            hold = tx_data;
            @(negedge clk);
            k++;
        end
        chk("dump_done", done, 1);
        busy_cyc += int'(busy);
        start = (poke == 2);
        @(negedge clk) start = 0;
        repeat (3) @(negedge clk);
        chk("post_busy", busy, 0);
        tx_ready = 0;
    endtask

    task automatic check_run(input string tag, input logic [7:0] csum, input int cyc);
        logic [7:0] e[$];
        for (int i = 0; i < 4; i++) e.push_back(ram[i]);
        if (CS == 1) e.push_back(csum);
        chk({tag, "_len"}, got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++) chk($sformatf("%s_b%0d", tag, i), got_q[i], e[i]);
        chk({tag, "_nreads"}, addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++) chk($sformatf("%s_a%0d", tag, i), addr_q[i], i);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_cyc"}, busy_cyc, cyc + CS);
        chk({tag, "_stable"}, unstable, 0);
    endtask

    task automatic wait_hs(input int n);
        int h = 0, k = 0;
        tx_ready = 1;
        while (h < n && k < 100) begin
            @(negedge clk);
            if (tx_valid) h++;
            k++;
        end
        chk("hs_reach", h, n);
    endtask

    typedef struct {
        logic [3:0][7:0] b;
        int stall_idx;
        int stall_len;
        int poke;
        logic [7:0] csum;
        int cyc;
    } vec_t;
    vec_t tbl[4];

    initial begin
        tbl[0] = '{32'h44332211, -1, 0, 0, 8'h56, 13};
        tbl[1] = '{32'h44332211,  1, 5, 0, 8'h56, 18};
        tbl[2] = '{32'h7F8001FF, -1, 0, 1, 8'h01, 13};
        tbl[3] = '{32'h00000000,  2, 1, 2, 8'h00, 14};
        repeat (2) @(negedge clk);
        chk("reset_out", {mem_ce, mem_addr, tx_data, tx_valid, busy, done}, 0);
        chk("reset_out_b", {ce_b, addr_b, data_b, valid_b, busy_b, done_b}, 0);
        n_reset = 1;
        @(negedge clk);
        addr_q.delete();
        start = 1;
        @(negedge clk) start = 0;
        repeat (3) @(negedge clk);
        chk("noload_busy", busy, 0);
        chk("noload_reads", addr_q.size(), 0);
        loaded = 1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) ram[i] = tbl[t].b[i];
            run_dump(tbl[t].stall_idx, tbl[t].stall_len, tbl[t].poke, 0);
            check_run($sformatf("vec%0d", t), tbl[t].csum, tbl[t].cyc);
        end
        for (int r = 0; r < 6; r++) begin
            int s = 0;
            for (int i = 0; i < 4; i++) begin ram[i] = 8'($urandom); s += int'(ram[i]); end
            run_dump(-1, 0, 0, 1);
            check_run($sformatf("rnd%0d", r), 8'((256 - s % 256) % 256), 13 + stall_seen);
        end
        addr_q.delete(); done_cnt = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        wait_hs(1);
        @(negedge clk) n_reset = 0;
        #1 chk("rst_abort_out", {mem_ce, mem_addr, tx_data, tx_valid, busy, done}, 0);
        @(negedge clk) n_reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_abort_done", done_cnt, 0);
        run_dump(-1, 0, 0, 0);
        check_run("after_rst", 8'((256 - (int'(ram[0]) + ram[1] + ram[2] + ram[3]) % 256) % 256), 13);
        addr_q.delete(); done_cnt = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        wait_hs(2);
        @(negedge clk) loaded = 0;
        @(negedge clk);
        chk("ld_abort_out", {mem_ce, mem_addr, tx_data, tx_valid, busy, done}, 0);
        loaded = 1;
        repeat (3) @(negedge clk);
        chk("ld_abort_done", done_cnt, 0);
        for (int i = 0; i < 4; i++) ram[i] = tbl[0].b[i];
        run_dump(-1, 0, 0, 0);
        check_run("after_ld", 8'h56, 13);
        begin
            int s = 0, k = 0;
            for (int a = 0; a < 4096; a++) s += a % 256;
            csum_b = 8'((256 - s % 256) % 256);
            @(negedge clk) start_b = 1;
            @(negedge clk) start_b = 0;
            while (!done_b && k < 20000) begin @(negedge clk); k++; end
            chk("big_done", done_b, 1);
            @(negedge clk);
            chk("big_count", nb, 4096 + CS);
            chk("big_bad", badb, 0);
            chk("big_maxaddr", maxa, 12'hFFF);
            chk("big_cyc", cyc_b, 3 * 4096 + CS + 1);
            chk("big_idle", busy_b, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
